// File: rtl/sup_counter_param.sv
// Parametrised modulo-N up/down counter with prescaler, parallel load,
// wrap/saturate limits, registered terminal-count pulse and sticky overflow.
module sup_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             cl,
  input  logic             r,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] o,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CntMax  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModWide = (WIDTH + 1)'(MODULUS);
  localparam logic [PW-1:0]    PLast   = PW'(PRESCALE - 1);

  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_lim;

  always_comb begin
    step   = en && (p_q == PLast);
    at_lim = up_dn ? (cnt_q >= CntMax) : (cnt_q == '0);
    p_d    = p_q;
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    if (load) begin
      // Out-of-range load values clamp to the top of the count range.
      p_d   = '0;
      cnt_d = ({1'b0, load_val} < ModWide) ? load_val : CntMax;
    end else if (en) begin
      p_d = step ? '0 : p_q + 1'b1;
      if (step) begin
        tc_d = at_lim;
        if (!at_lim) begin
          cnt_d = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end else if (SATURATE == 0) begin
          cnt_d = up_dn ? '0 : CntMax;
        end
      end
    end
    // A limit step in the same cycle as clr_ovf leaves the flag set.
    ovf_d = tc_d | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge cl) begin
    if (r) begin
      p_q   <= '0;
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign o   = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_sup_counter_param.sv
// Scoreboard bench: three counter configurations share stimulus; each cycle's
// expectation names the instance it applies to and a monitor compares it.
module tb_sup_counter_param;

  logic       cl;
  logic       r, en, up_dn, load, clr_ovf;
  logic [3:0] load_val;

  logic [3:0] o_a, o_b, o_c;
  logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  // a: wrap, prescale 1; b: saturate; c: prescale 3
  sup_counter_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
    .cl(cl), .r(r), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .o(o_a), .tc(tc_a), .ovf(ovf_a)
  );
  sup_counter_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_b (
    .cl(cl), .r(r), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .o(o_b), .tc(tc_b), .ovf(ovf_b)
  );
  sup_counter_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_c (
    .cl(cl), .r(r), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .o(o_c), .tc(tc_c), .ovf(ovf_c)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] o;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    cl = 1'b0;
    forever #5 cl = ~cl;
  end

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic cyc(input logic rr, input logic ee, input logic ud, input logic ld,
                     input logic [3:0] lv, input logic cc, input logic [1:0] id,
                     input logic [3:0] eo, input logic etc, input logic eovf);
    exp_t e;
    @(negedge cl);
    r = rr; en = ee; up_dn = ud; load = ld; load_val = lv; clr_ovf = cc;
    e.id = id; e.o = eo; e.tc = etc; e.ovf = eovf;
    exp_q.push_back(e);
  endtask

  // Monitor: the counter presents a result every cycle, one entry per edge.
  initial begin
    exp_t       e;
    logic [3:0] ao;
    logic       atc, aovf;
    forever begin
      @(posedge cl);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        unique case (e.id)
          2'd0:    begin ao = o_a; atc = tc_a; aovf = ovf_a; end
          2'd1:    begin ao = o_b; atc = tc_b; aovf = ovf_b; end
          default: begin ao = o_c; atc = tc_c; aovf = ovf_c; end
        endcase
        checks++;
        if (ao !== e.o || atc !== e.tc || aovf !== e.ovf) begin
          errors++;
          $display("FAIL check%0d dut%0d: got o=%0d tc=%0b ovf=%0b, required o=%0d tc=%0b ovf=%0b",
                   checks, e.id, ao, atc, aovf, e.o, e.tc, e.ovf);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    r = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;

    // Reset overrides load and enable
    cyc(1, 1, 1, 1, 4'd5, 0, 0, 4'd0, 0, 0);
    cyc(1, 1, 1, 1, 4'd5, 0, 0, 4'd0, 0, 0);
    // Count up through the wrap
    for (int i = 1; i <= 9; i++) cyc(0, 1, 1, 0, 4'd0, 0, 0, 4'(i), 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 0, 4'd0, 1, 1);
    cyc(0, 1, 1, 0, 4'd0, 0, 0, 4'd1, 0, 1);
    cyc(0, 1, 1, 0, 4'd0, 0, 0, 4'd2, 0, 1);
    // Down wrap, clear racing a limit step, then clear alone
    cyc(0, 0, 0, 1, 4'd0, 0, 0, 4'd0, 0, 1);
    cyc(0, 1, 0, 0, 4'd0, 0, 0, 4'd9, 1, 1);
    cyc(0, 0, 0, 1, 4'd0, 0, 0, 4'd0, 0, 1);
    cyc(0, 1, 0, 0, 4'd0, 1, 0, 4'd9, 1, 1);
    cyc(0, 0, 0, 0, 4'd0, 1, 0, 4'd9, 0, 0);
    cyc(0, 0, 0, 0, 4'd0, 0, 0, 4'd9, 0, 0);
    cyc(0, 1, 0, 0, 4'd0, 0, 0, 4'd8, 0, 0);

    // Saturating instance
    cyc(1, 0, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0);
    cyc(0, 0, 1, 1, 4'd7, 0, 1, 4'd7, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 1, 4'd8, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 1, 4'd9, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 1, 4'd9, 1, 1);
    cyc(0, 1, 1, 0, 4'd0, 0, 1, 4'd9, 1, 1);
    cyc(0, 1, 1, 0, 4'd0, 0, 1, 4'd9, 1, 1);
    cyc(0, 0, 0, 1, 4'd0, 0, 1, 4'd0, 0, 1);
    cyc(0, 1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1);
    cyc(0, 1, 1, 0, 4'd0, 0, 1, 4'd1, 0, 1);

    // Prescale by 3: steps on enabled cycles 3, 6, 9
    cyc(1, 0, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    for (int i = 1; i <= 9; i++) cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'(i / 3), 0, 0);
    // Two idle cycles slip the first step from cycle 3 to cycle 5
    cyc(1, 0, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    cyc(0, 0, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    cyc(0, 0, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd1, 0, 0);
    cyc(0, 1, 0, 0, 4'd0, 0, 2, 4'd1, 0, 0);
    cyc(0, 1, 0, 0, 4'd0, 0, 2, 4'd1, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd2, 0, 0);
    // Reset with p=2 discards the partial prescale
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd2, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd2, 0, 0);
    cyc(1, 1, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd0, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd1, 0, 0);
    // Clamped load at a prescale boundary wins and restarts the prescaler
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd1, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd1, 0, 0);
    cyc(0, 1, 1, 1, 4'd12, 0, 2, 4'd9, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd9, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd9, 0, 0);
    cyc(0, 1, 1, 0, 4'd0, 0, 2, 4'd0, 1, 1);
    cyc(0, 0, 1, 0, 4'd0, 0, 2, 4'd0, 0, 1);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge cl);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
